// File: rtl/flash_arbiter_if.sv
// rtl/flash_arbiter_if.sv - requester and flash-slave bus bundle for flash_arbiter
interface flash_arbiter_if;
    logic [23:0] m0_adr_i;
    logic [31:0] m0_dat_i;
    logic        m0_we_i;
    logic        m0_stb_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    logic [23:0] m1_adr_i;
    logic [31:0] m1_dat_i;
    logic        m1_we_i;
    logic        m1_stb_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    logic [23:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_rty_i;

    // slave: the arbiter's view; master: the surrounding requesters and flash model
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_rty_i
    );
    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_stb_o,
        output s_dat_i, s_ack_i, s_rty_i
    );
endinterface

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - round-robin two-requester arbiter for the SPI flash slave with retry and timeout
module flash_arbiter #(
    parameter int RETRY_GAP = 64,
    parameter int MAX_RETRY = 255,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    flash_arbiter_if.slave bus,
    output logic           busy_o,
    output logic           grant_o
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(RETRY_GAP);
    localparam logic [TW-1:0] TMR_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_GAP, S_DONE} state_t;

    state_t        state, state_n;
    logic          last, last_n, grant_n, busy_n;
    logic [23:0]   adr, adr_n;
    logic [31:0]   wdat, wdat_n;
    logic          we, we_n, stb, stb_n;
    logic [31:0]   m0_rdat, m0_rdat_n, m1_rdat, m1_rdat_n;
    logic          m0_ack, m0_ack_n, m0_err, m0_err_n;
    logic          m1_ack, m1_ack_n, m1_err, m1_err_n;
    logic [RW-1:0] retry, retry_n;
    logic [GW-1:0] gap, gap_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          req, pick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            grant_o <= 1'b0;
            busy_o  <= 1'b0;
            adr     <= '0;
            wdat    <= '0;
            we      <= 1'b0;
            stb     <= 1'b0;
            m0_rdat <= '0;
            m1_rdat <= '0;
            m0_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
            retry   <= '0;
            gap     <= '0;
            tmr     <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            grant_o <= grant_n;
            busy_o  <= busy_n;
            adr     <= adr_n;
            wdat    <= wdat_n;
            we      <= we_n;
            stb     <= stb_n;
            m0_rdat <= m0_rdat_n;
            m1_rdat <= m1_rdat_n;
            m0_ack  <= m0_ack_n;
            m0_err  <= m0_err_n;
            m1_ack  <= m1_ack_n;
            m1_err  <= m1_err_n;
            retry   <= retry_n;
            gap     <= gap_n;
            tmr     <= tmr_n;
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        grant_n   = grant_o;
        adr_n     = adr;
        wdat_n    = wdat;
        we_n      = we;
        stb_n     = stb;
        m0_rdat_n = m0_rdat;
        m1_rdat_n = m1_rdat;
        m0_ack_n  = 1'b0;
        m0_err_n  = 1'b0;
        m1_ack_n  = 1'b0;
        m1_err_n  = 1'b0;
        retry_n   = retry;
        gap_n     = gap;
        tmr_n     = tmr;
        req       = bus.m0_stb_i | bus.m1_stb_i;
        // On a tie the requester that did not win last time goes next
        pick      = (bus.m0_stb_i && bus.m1_stb_i) ? ~last : bus.m1_stb_i;

        case (state)
            S_IDLE: begin
                if (req) begin
                    grant_n = pick;
                    last_n  = pick;
                    adr_n   = pick ? bus.m1_adr_i : bus.m0_adr_i;
                    wdat_n  = pick ? bus.m1_dat_i : bus.m0_dat_i;
                    we_n    = pick ? bus.m1_we_i  : bus.m0_we_i;
                    retry_n = '0;
                    tmr_n   = '0;
                    stb_n   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tmr != TMR_LAST) tmr_n = tmr + TW'(1);
                if (bus.s_ack_i) begin
                    stb_n   = 1'b0;
                    state_n = S_DONE;
                    if (grant_o) begin
                        m1_rdat_n = bus.s_dat_i;
                        m1_ack_n  = 1'b1;
                    end else begin
                        m0_rdat_n = bus.s_dat_i;
                        m0_ack_n  = 1'b1;
                    end
                end else if (bus.s_rty_i && retry != RETRY_LAST) begin
                    stb_n   = 1'b0;
                    retry_n = retry + RW'(1);
                    gap_n   = GAP_LOAD;
                    state_n = S_WAIT_GAP;
                end else if (bus.s_rty_i || tmr == TMR_LAST) begin
                    stb_n    = 1'b0;
                    state_n  = S_DONE;
                    m1_err_n = grant_o;
                    m0_err_n = ~grant_o;
                end
            end
            S_WAIT_GAP: begin
                if (gap == GW'(1)) begin
                    stb_n   = 1'b1;
                    tmr_n   = '0;
                    state_n = S_ISSUE;
                end else begin
                    gap_n = gap - GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    assign bus.s_adr_o  = adr;
    assign bus.s_dat_o  = wdat;
    assign bus.s_we_o   = we;
    assign bus.s_stb_o  = stb;
    assign bus.m0_dat_o = m0_rdat;
    assign bus.m1_dat_o = m1_rdat;
    assign bus.m0_ack_o = m0_ack;
    assign bus.m0_err_o = m0_err;
    assign bus.m1_ack_o = m1_ack;
    assign bus.m1_err_o = m1_err;
endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - scoreboard bench for flash_arbiter with a scripted flash slave model
module tb_flash_arbiter;
    localparam int K_ACK = 0, K_RTY = 1, K_SILENT = 2, K_BOTH = 3;

    typedef struct {
        int          kind;
        int          delay;
        logic [23:0] adr;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        bit          who;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic busy, grant;
    flash_arbiter_if bus();

    flash_arbiter #(.RETRY_GAP(4), .MAX_RETRY(2), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus), .busy_o(busy), .grant_o(grant)
    );

    always #5 clk_i = ~clk_i;

    int    checks = 0;
    int    fails = 0;
    resp_t resp_q[$];
    exp_t  exp_q[$];
    int    gap_log[$];
    int    pulses = 0;
    int    last_high = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t mk(input int kind, input int delay, input logic [23:0] adr,
                                 input logic [31:0] data);
        resp_t r;
        r.kind = kind; r.delay = delay; r.adr = adr; r.data = data;
        return r;
    endfunction

    function automatic exp_t ex(input bit who, input bit err, input logic [31:0] data);
        exp_t e;
        e.who = who; e.err = err; e.data = data;
        return e;
    endfunction

    // Flash slave model: one scripted response per strobe pulse, driven at negedge
    initial begin
        bit    in_attempt = 0;
        bit    after_rty = 0;
        int    cnt = 0, high_len = 0, low_len = 0;
        resp_t cur;
        bus.s_ack_i = 0; bus.s_rty_i = 0; bus.s_dat_i = '0;
        cur = mk(K_SILENT, 0, '0, '0);
        forever begin
            @(negedge clk_i);
            bus.s_ack_i = 0;
            bus.s_rty_i = 0;
            if (bus.s_stb_o) begin
                if (!in_attempt) begin
                    in_attempt = 1; pulses++; cnt = 0; high_len = 0;
                    if (after_rty) gap_log.push_back(low_len);
                    if (resp_q.size() > 0) begin
                        cur = resp_q.pop_front();
                        check("s_adr", {8'h0, bus.s_adr_o}, {8'h0, cur.adr});
                    end else begin
                        cur = mk(K_SILENT, 0, '0, '0);
                    end
                end
                cnt++; high_len++;
                if (cur.kind != K_SILENT && cnt == cur.delay) begin
                    bus.s_ack_i = (cur.kind != K_RTY);
                    bus.s_rty_i = (cur.kind == K_RTY) || (cur.kind == K_BOTH);
                    bus.s_dat_i = cur.data;
                end
            end else begin
                if (in_attempt) begin
                    in_attempt = 0; last_high = high_len; low_len = 0;
                    after_rty = (cur.kind == K_RTY);
                end
                low_len++;
            end
        end
    end

    // Termination monitor: pops the scoreboard whenever any ack/err is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && (bus.m0_ack_o || bus.m0_err_o || bus.m1_ack_o || bus.m1_err_o)) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_term: got termination expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("term_one_hot", $countones({bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}), 1);
                    check("term_who", bus.m1_ack_o | bus.m1_err_o, e.who);
                    check("term_err", bus.m0_err_o | bus.m1_err_o, e.err);
                    check("term_grant", grant, e.who);
                    check("term_stb_low", bus.s_stb_o, 0);
                    if (!e.err) check("rd_data", e.who ? bus.m1_dat_o : bus.m0_dat_o, e.data);
                end
            end
        end
    end

    task automatic req(input bit who, input logic [23:0] adr, input logic [31:0] dat, input bit we);
        int n = 0;
        if (who) begin
            bus.m1_adr_i = adr; bus.m1_dat_i = dat; bus.m1_we_i = we; bus.m1_stb_i = 1;
        end else begin
            bus.m0_adr_i = adr; bus.m0_dat_i = dat; bus.m0_we_i = we; bus.m0_stb_i = 1;
        end
        do begin
            @(negedge clk_i);
            n++;
        end while (!(who ? (bus.m1_ack_o | bus.m1_err_o) : (bus.m0_ack_o | bus.m0_err_o)) && n < 300);
        if (n >= 300) begin
            checks++; fails++;
            $display("FAIL req_timeout: got no termination expected one for m%0d", who);
        end
        if (who) bus.m1_stb_i = 0; else bus.m0_stb_i = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit seen;
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_we_i = 0; bus.m0_stb_i = 0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_we_i = 0; bus.m1_stb_i = 0;
        repeat (3) @(negedge clk_i);
        check("rst_stb", bus.s_stb_o, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_adr", {8'h0, bus.s_adr_o}, 0);
        check("rst_m0_ack", bus.m0_ack_o, 0);
        check("rst_m1_dat", bus.m1_dat_o, 0);
        rst_ni = 1;
        @(negedge clk_i);

        // Simultaneous requests alternate m0,m1,m0,m1; the last ack also sees rty
        resp_q.push_back(mk(K_ACK, 2, 24'h000A00, 32'h1111_0000));
        resp_q.push_back(mk(K_ACK, 2, 24'h000B00, 32'h2222_0000));
        resp_q.push_back(mk(K_ACK, 2, 24'h000A04, 32'h1111_0004));
        resp_q.push_back(mk(K_BOTH, 2, 24'h000B04, 32'h2222_0004));
        exp_q.push_back(ex(0, 0, 32'h1111_0000));
        exp_q.push_back(ex(1, 0, 32'h2222_0000));
        exp_q.push_back(ex(0, 0, 32'h1111_0004));
        exp_q.push_back(ex(1, 0, 32'h2222_0004));
        fork
            begin req(0, 24'h000A00, 32'h0, 0); @(negedge clk_i); req(0, 24'h000A04, 32'h0, 0); end
            begin req(1, 24'h000B00, 32'h0, 0); @(negedge clk_i); req(1, 24'h000B04, 32'h0, 0); end
        join
        repeat (3) @(negedge clk_i);

        // Single read: 1-cycle strobe latency, ack in the third strobe cycle
        resp_q.push_back(mk(K_ACK, 3, 24'h000100, 32'hDEADBEEF));
        exp_q.push_back(ex(0, 0, 32'hDEADBEEF));
        fork
            req(0, 24'h000100, 32'h0, 0);
            begin
                @(negedge clk_i);
                check("stb_latency", bus.s_stb_o, 1);
                check("busy_in_xfer", busy, 1);
            end
        join
        @(negedge clk_i);
        check("busy_after", busy, 0);
        check("m0_dat_hold", bus.m0_dat_o, 32'hDEADBEEF);

        // Two retries then ack, write from m1
        gap_log.delete();
        p0 = pulses;
        resp_q.push_back(mk(K_RTY, 1, 24'h000200, 32'h0));
        resp_q.push_back(mk(K_RTY, 2, 24'h000200, 32'h0));
        resp_q.push_back(mk(K_ACK, 1, 24'h000200, 32'hCAFE0001));
        exp_q.push_back(ex(1, 0, 32'hCAFE0001));
        fork
            req(1, 24'h000200, 32'h5A5A_A5A5, 1);
            begin
                @(negedge clk_i);
                check("s_we", bus.s_we_o, 1);
                check("s_dat", bus.s_dat_o, 32'h5A5A_A5A5);
            end
        join
        check("retry_pulses", pulses - p0, 3);
        check("retry_gaps", gap_log.size(), 2);
        foreach (gap_log[i]) check("gap_len", gap_log[i], 4);
        @(negedge clk_i);

        // Retry exhaustion: three rty answers give err
        gap_log.delete();
        p0 = pulses;
        repeat (3) resp_q.push_back(mk(K_RTY, 1, 24'h000300, 32'h0));
        exp_q.push_back(ex(0, 1, 32'h0));
        req(0, 24'h000300, 32'h0, 0);
        check("exhaust_pulses", pulses - p0, 3);
        check("exhaust_gaps", gap_log.size(), 2);
        foreach (gap_log[i]) check("exhaust_gap_len", gap_log[i], 4);
        check("m0_dat_kept", bus.m0_dat_o, 32'hDEADBEEF);
        @(negedge clk_i);

        // Silent slave times out after 16 strobe cycles
        resp_q.push_back(mk(K_SILENT, 0, 24'h000400, 32'h0));
        exp_q.push_back(ex(0, 1, 32'h0));
        req(0, 24'h000400, 32'h0, 0);
        check("timeout_stb_len", last_high, 16);
        @(negedge clk_i);

        // Ack in the final timeout cycle wins
        resp_q.push_back(mk(K_ACK, 16, 24'h000500, 32'h0BADF00D));
        exp_q.push_back(ex(1, 0, 32'h0BADF00D));
        req(1, 24'h000500, 32'h0, 0);
        check("late_ack_stb_len", last_high, 16);
        @(negedge clk_i);

        // Reset during WAIT_GAP drops the transaction
        resp_q.push_back(mk(K_RTY, 1, 24'h000600, 32'h0));
        bus.m1_adr_i = 24'h000600; bus.m1_we_i = 0; bus.m1_stb_i = 1;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (bus.s_stb_o) seen = 1;
            else if (seen) break;
        end
        check("reached_gap", seen && !bus.s_stb_o && busy, 1);
        #2 rst_ni = 0;
        #1;
        check("mid_rst_stb", bus.s_stb_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_m1_dat", bus.m1_dat_o, 0);
        check("mid_rst_m0_dat", bus.m0_dat_o, 0);
        bus.m1_stb_i = 0;
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        resp_q.push_back(mk(K_ACK, 2, 24'h000700, 32'h7777_7777));
        exp_q.push_back(ex(1, 0, 32'h7777_7777));
        req(1, 24'h000700, 32'h0, 0);
        repeat (3) @(negedge clk_i);

        check("scoreboard_empty", exp_q.size(), 0);
        check("resp_script_empty", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
Shares the single SPI flash bus slave between two requesters (m0, m1). Typical pairing is a sample/patch reader and a config loader. Arbitrates round-robin and forwards one transaction at a time. Retries automatically when the flash answers rty (device busy), with a programmable gap, and turns retry exhaustion or a missing response into an error termination. Sits between the requesters and the flash slave port in the top level.

Parameters:
RETRY_GAP, 64, idle cycles with s_stb_o low between a rty and the reissue (>=1)
MAX_RETRY, 255, rty responses tolerated before error; total attempts = MAX_RETRY+1
TIMEOUT, 4096, cycles in ISSUE without ack/rty before error (>=2)

Ports:
clk_i  in  1  system clock, 100 MHz
rst_ni  in  1  asynchronous active-low reset
m0_adr_i  in  24  requester 0 flash address
m0_dat_i  in  32  requester 0 write data
m0_we_i  in  1  requester 0 write enable
m0_stb_i  in  1  requester 0 request; held until m0_ack_o or m0_err_o
m0_dat_o  out  32  read data to requester 0; valid while m0_ack_o
m0_ack_o  out  1  one-cycle success termination
m0_err_o  out  1  one-cycle error termination (retries exhausted or timeout)
m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0, for requester 1
s_adr_o  out  24  address to flash slave
s_dat_o  out  32  write data to flash slave
s_we_o  out  1  write enable to flash slave
s_stb_o  out  1  strobe to flash slave
s_dat_i  in  32  read data from flash slave
s_ack_i  in  1  flash slave ack
s_rty_i  in  1  flash slave retry (status busy)
busy_o  out  1  high in any state other than IDLE
grant_o  out  1  index of the requester currently owning the slave

Behaviour:
- Reset (rst_ni low, async): state=IDLE; all outputs 0 (s_*, m*_dat_o, m*_ack_o, m*_err_o, busy_o, grant_o); last-grant pointer=1, so m0 wins the first tie.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - One requester's stb high: grant it.
  - Both high: grant the one not equal to the last-grant pointer.
  - On grant, latch adr/dat/we into s_adr_o/s_dat_o/s_we_o, set grant_o and the last-grant pointer, clear retry and timeout counters, set s_stb_o=1, go ISSUE.
  - s_stb_o rises on the edge after the requester's stb is sampled high (1-cycle latency).
- ISSUE (s_stb_o=1; timeout counter increments each cycle):
  - s_ack_i: capture s_dat_i into the granted m*_dat_o, set that m*_ack_o, s_stb_o=0, go DONE.
  - s_rty_i (no ack), retry count < MAX_RETRY: s_stb_o=0, retry count +1, load gap counter with RETRY_GAP, go WAIT_GAP.
  - s_rty_i (no ack), retry count == MAX_RETRY: s_stb_o=0, set granted m*_err_o, go DONE.
  - s_ack_i and s_rty_i in the same cycle: treat as ack.
  - Timeout counter reaches TIMEOUT-1 with neither ack nor rty: s_stb_o=0, set m*_err_o, go DONE.
  - Ack/rty arriving in that same final cycle takes priority over the timeout.
- WAIT_GAP: s_stb_o=0 (this returns the flash controller to idle and deasserts chip select). Decrement the gap counter. At 1, set s_stb_o=1, clear the timeout counter, go ISSUE. s_adr_o/s_dat_o/s_we_o remain unchanged.
- DONE: exactly one cycle with m*_ack_o or m*_err_o high, then clear both and return to IDLE. No grant is evaluated in DONE.
- m*_dat_o holds its last value until the next successful read for that requester.
- Requester inputs are ignored while not granted. A granted requester dropping stb mid-transaction does not abort it; the termination is still issued.
- Counter widths: $clog2(MAX_RETRY+1), $clog2(RETRY_GAP+1), $clog2(TIMEOUT+1). Counters never wrap.
- Reset asserted mid-transaction: immediate return to the reset state; the in-flight transaction is dropped with no ack/err.

Test Plan:
- m0 read adr 0x000100; slave acks 3 cycles after s_stb_o rises with 0xDEADBEEF -> m0_ack_o 1 cycle, m0_dat_o=0xDEADBEEF, s_stb_o low for DONE, busy_o low after.
- m0 and m1 strobe in the same cycle, repeated 4 transactions -> grants alternate m0,m1,m0,m1; grant_o matches; m1 never acked while m0 granted.
- Slave answers rty twice then ack (RETRY_GAP=4) -> s_stb_o low exactly 4 cycles after each rty, 3 s_stb_o pulses total, single m*_ack_o, no err.
- MAX_RETRY=2, slave always rty -> 3 attempts, then m*_err_o 1 cycle, m*_ack_o stays 0.
- TIMEOUT=16, slave silent -> s_stb_o high 16 cycles, then m*_err_o; same cycle-16 with s_ack_i high -> ack instead of err.
- rst_ni pulsed low during WAIT_GAP -> all outputs 0 immediately; after release a new m1 request is served normally.
